serial_divider: RTL and testbench
=================================

# serial_divider

Multi-cycle radix-2 restoring divider that executes the RISC-V M-extension DIV, DIVU, REM and REMU operations. It is the subtract-based counterpart to the core's adder datapath. It sits beside the ALU and is started by the execute stage. The stage stalls on BUSY and collects RESULT on the DONE pulse. Latency is fixed and independent of operand values.

## Interface
- XLEN, 32, operand/result width (≥ 4)
- CLK  in  1  rising-edge clock
- RST_N  in  1  reset, asynchronous, active-low
- START  in  1  request; accepted only when BUSY = 0
- OP  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with START
- A  in  XLEN  dividend; sampled with START
- B  in  XLEN  divisor; sampled with START
- BUSY  out  1  operation in progress
- DONE  out  1  single-cycle pulse, RESULT valid
- RESULT  out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU)

## Operation
- States:
  - IDLE: accept START.
  - CALC: XLEN iterations, counter XLEN-1 down to 0.
  - FIX: sign/special-case correction, RESULT register load.
  - IDLE again, with DONE pulsed.
- Capture on START in IDLE, when signed and the operand is negative:
  - store |A| in the dividend/quotient shift register,
  - store |B| in the divisor register,
  - latch OP and both operand signs, clear the XLEN+1-bit partial remainder,
  - later changes on A/B/OP have no effect.
- CALC iteration:
  - rem ← {rem[XLEN-1:0], q[XLEN-1]}; q shifts left.
  - diff = rem − {0, div}.
  - If no borrow, rem ← diff and q[0] ← 1; otherwise q[0] ← 0.
- FIX:
  - Signed quotient is negated when sign(A) ≠ sign(B).
  - Signed remainder takes the sign of A.
  - Divide-by-zero: quotient = all ones (DIV and DIVU), remainder = A as captured. This overrides sign correction.
  - Signed overflow (A = −2^(XLEN−1), B = −1): quotient = A, remainder = 0.
- Arithmetic is modulo 2^XLEN and never traps.
- START while BUSY is ignored; no queuing.
- START in the same cycle as DONE is accepted, because BUSY is already 0 then.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - state IDLE, BUSY 0, DONE 0, RESULT 0, all internal registers 0.
- START sampled high at edge k in IDLE:
  - BUSY = 1 after edge k, through edge k+XLEN+1.
  - CALC occupies edges k+1 … k+XLEN.
  - FIX occupies edge k+XLEN+1.
- After edge k+XLEN+1:
  - BUSY = 0, DONE = 1 for exactly one cycle, RESULT updated.
  - Latency is XLEN+1 cycles (33 for XLEN = 32) for every input, special cases included.
- RESULT holds its value until the next FIX. It does not change on START.
- Reset asserted mid-operation aborts immediately. No DONE is produced and RESULT clears to 0.

## Structure
- Shared package:
  - OP encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU),
  - state encoding (IDLE, CALC, FIX),
  - XLEN default.
- Sub-module `ripple_subtractor`:
  - combinational XLEN+1-bit A + ~B + 1 built from the existing full-adder cell,
  - outputs DIFF and BORROW.
- The divider instantiates it once for the iteration step and reuses it for two's-complement negation in capture/FIX via a mux, or instantiates a second copy.
- Counter width: clog2(XLEN).

## Test plan
- DIVU A=100, B=7 → BUSY high 33 cycles, DONE one cycle, RESULT=14; repeat with REMU → 2.
- DIV A=−7 (0xFFFFFFF9), B=2 → 0xFFFFFFFD (−3); REM same operands → 0xFFFFFFFF (−1).
- Divide by zero, A=0x1234: DIV and DIVU → 0xFFFFFFFF; REM and REMU → 0x1234; latency still 33.
- Overflow, A=0x80000000, B=0xFFFFFFFF: DIV → 0x80000000, REM → 0.
- START again and A/B changes during BUSY → ignored, original result delivered. Back-to-back START on the DONE cycle → second result 33 cycles later.
- RST_N pulsed low at cycle 10 of an operation → BUSY, DONE and RESULT 0 at once, no DONE afterwards. A fresh START then completes normally.

Source files
------------

// File: rtl/serial_divider_pkg.sv
// serial_divider_pkg: shared encodings for the radix-2 restoring divider.
// Contents: XLEN default, RISC-V M-extension divide opcodes, FSM state encoding,
//           and small opcode decode helpers used by the divider and its bench.
package serial_divider_pkg;

  // Default operand/result width (must be >= 4).
  localparam int XLEN_DEFAULT = 32;

  // Operation select, sampled together with start.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_t;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

  // Bit 0 clear means the operands are two's-complement signed.
  function automatic logic op_is_signed(op_t op);
    return ~op[0];
  endfunction

  // Bit 1 set selects the remainder instead of the quotient.
  function automatic logic op_is_rem(op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/serial_divider_if.sv
// serial_divider_if: request/response bundle between the execute stage and the divider.
// master: execute stage (drives start/op/a/b, observes busy/done/result).
// slave : divider (samples start/op/a/b, drives busy/done/result).
interface serial_divider_if
  import serial_divider_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic            start;   // request, honoured only while busy is low
  op_t             op;      // operation, sampled with start
  logic [XLEN-1:0] a;       // dividend, sampled with start
  logic [XLEN-1:0] b;       // divisor, sampled with start
  logic            busy;    // operation in progress
  logic            done;    // one-cycle pulse, result valid
  logic [XLEN-1:0] result;  // quotient or remainder, held until the next completion

  modport master (
    output start, op, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result
  );

endinterface

// File: rtl/serial_divider_ripple_subtractor.sv
// ripple_subtractor: combinational W-bit x - y computed as x + ~y + 1 on a
// chain of full-adder cells. Ports: x, y (operands), diff (x - y mod 2^W),
// borrow (high when x < y unsigned, i.e. the final carry is clear).

// full_adder: single-bit sum/carry cell. Ports: a, b, ci in; s, co out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module ripple_subtractor #(
  parameter int W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0]   carry;
  logic [W-1:0] y_inv;

  assign y_inv    = ~y;
  // Carry-in of 1 completes the two's complement of y.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a  (x[i]),
      .b  (y_inv[i]),
      .ci (carry[i]),
      .s  (diff[i]),
      .co (carry[i+1])
    );
  end

  // No carry out of the top bit means the subtraction wrapped.
  assign borrow = ~carry[W];

endmodule

// File: rtl/serial_divider.sv
// serial_divider: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Ports: clk, rst_n (async active-low), bus (serial_divider_if.slave: start/op/a/b
//        in, busy/done/result out). Fixed latency XLEN+1 cycles from start to done.
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_divider_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN:0] ZERO_EXT = '0;

  // ---------------------------------------------------------------- state
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   rem_q;     // partial remainder, one bit wider than the divisor
  logic [XLEN-1:0] quo_q;     // dividend shifting out / quotient shifting in
  logic [XLEN-1:0] dvs_q;     // |divisor|
  logic [XLEN-1:0] result_q;
  op_t             op_q;
  logic            a_neg_q;   // dividend was negative and the op is signed
  logic            b_neg_q;   // divisor was negative and the op is signed
  logic            done_q;

  logic capture, iterate, finish;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    iterate = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          capture = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        iterate = 1'b1;
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // ---------------------------------------------------------------- datapath
  logic [XLEN:0] rem_shift;
  logic [XLEN:0] step_x, step_y, step_diff;
  logic          step_borrow;
  logic [XLEN:0] neg_y, neg_diff;
  logic          neg_borrow;
  logic          a_neg_in, b_neg_in;

  assign rem_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign a_neg_in  = op_is_signed(bus.op) & bus.a[XLEN-1];
  assign b_neg_in  = op_is_signed(bus.op) & bus.b[XLEN-1];

  // The step subtractor is idle in IDLE, so it doubles as the negator that
  // forms |b| at capture; otherwise it compares the shifted remainder with
  // the divisor.
  always_comb begin
    step_x = rem_shift;
    step_y = {1'b0, dvs_q};
    if (state_q == IDLE) begin
      step_x = ZERO_EXT;
      step_y = {bus.b[XLEN-1], bus.b};
    end
  end

  // Second subtractor negates: |a| at capture, the selected raw result in FIX.
  always_comb begin
    neg_y = {1'b0, quo_q};
    if (state_q == IDLE) begin
      neg_y = {bus.a[XLEN-1], bus.a};
    end else if (op_is_rem(op_q)) begin
      neg_y = {1'b0, rem_q[XLEN-1:0]};
    end
  end

  ripple_subtractor #(.W(XLEN + 1)) u_step (
    .x      (step_x),
    .y      (step_y),
    .diff   (step_diff),
    .borrow (step_borrow)
  );

  ripple_subtractor #(.W(XLEN + 1)) u_neg (
    .x      (ZERO_EXT),
    .y      (neg_y),
    .diff   (neg_diff),
    .borrow (neg_borrow)
  );

  // Final correction.
  // Divide-by-zero: the restoring loop yields an all-ones quotient and a
  // remainder of |a|; re-applying a's sign to that remainder gives back a as
  // captured, so only the quotient needs an explicit override here.
  // Signed overflow (-2^(XLEN-1) / -1): |a| = 2^(XLEN-1), quotient negates
  // back to itself and the remainder is zero, so no special path is needed.
  logic            signed_op;
  logic [XLEN-1:0] quo_fix, rem_fix, res_fix;

  always_comb begin
    signed_op = op_is_signed(op_q);
    quo_fix   = quo_q;
    rem_fix   = rem_q[XLEN-1:0];
    if (dvs_q == '0) begin
      quo_fix = '1;
    end else if (signed_op && (a_neg_q ^ b_neg_q)) begin
      quo_fix = neg_diff[XLEN-1:0];
    end
    if (signed_op && a_neg_q) begin
      rem_fix = neg_diff[XLEN-1:0];
    end
    res_fix = op_is_rem(op_q) ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      op_q     <= OP_DIV;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= finish;
      if (capture) begin
        rem_q   <= '0;
        quo_q   <= a_neg_in ? neg_diff[XLEN-1:0] : bus.a;
        dvs_q   <= b_neg_in ? step_diff[XLEN-1:0] : bus.b;
        op_q    <= bus.op;
        a_neg_q <= a_neg_in;
        b_neg_q <= b_neg_in;
        cnt_q   <= CNT_LAST;
      end else if (iterate) begin
        // Restore on borrow: keep the shifted remainder and record a 0.
        if (!step_borrow) begin
          rem_q <= step_diff;
          quo_q <= {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q <= rem_shift;
          quo_q <= {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_q <= cnt_q - CW'(1);
      end else if (finish) begin
        result_q <= res_fix;
      end
    end
  end

  // The negator's borrow and top bit, and the remainder's guard bit after the
  // last step, carry no information the design needs.
  logic unused_bits;
  assign unused_bits = &{1'b0, neg_borrow, neg_diff[XLEN], rem_q[XLEN]};

endmodule

// File: tb/tb_serial_divider.sv
module tb_serial_divider;
  import serial_divider_pkg::*;

  localparam int XLEN = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_divider_if #(.XLEN(XLEN)) bus ();

  serial_divider #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain integer arithmetic plus the RISC-V special cases.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b11:   return (b == 0) ? a : a % b;
      2'b00: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return sa / sb;
      end
      default: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return sa % sb;
      end
    endcase
  endfunction

  // Issue one operation and wait (bounded) for done. With sync=0 the request
  // is raised in the current cycle (used for the start-on-done case).
  task automatic run_check(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp,
                           input bit sync, input bit disturb);
    logic [31:0] prev;
    int n;
    int busy_cnt;
    bit held;
    if (sync) @(negedge clk);
    prev     = bus.result;
    held     = 1'b1;
    busy_cnt = 0;
    bus.start = 1'b1;
    bus.op    = op_t'(op);
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin
      if (bus.busy) busy_cnt++;
      if (bus.result !== prev) held = 1'b0;
      @(negedge clk);
      n++;
      if (disturb) begin
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.op    = op_t'($urandom_range(0, 3));
        bus.start = (n == 5);
      end
    end
    check({name, "_res"}, bus.result, exp);
    check({name, "_lat"}, n, 33);
    check({name, "_busy"}, busy_cnt, 33);
    check({name, "_hold"}, 32'(held), 32'd1);
    check({name, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bit          saw_done;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_DIV;
    bus.a     = '0;
    bus.b     = '0;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[4]  = '{2'b00, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF};
    vecs[5]  = '{2'b01, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF};
    vecs[6]  = '{2'b10, 32'h0000_1234,  32'd0,          32'h0000_1234};
    vecs[7]  = '{2'b11, 32'h0000_1234,  32'd0,          32'h0000_1234};
    vecs[8]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[9]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0};
    vecs[10] = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    vecs[11] = '{2'b10, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    rst_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1, 1'b0);
    end

    // Done lasts one cycle and the result is held afterwards.
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
    check("result_after", bus.result, vecs[11].exp);

    // start and operand changes while busy are ignored.
    run_check("busy_ignore", 2'b01, 32'd1000, 32'd10, 32'd100, 1'b1, 1'b1);
    bus.start = 1'b0;

    // Back-to-back: second request raised in the done cycle.
    run_check("b2b_first", 2'b01, 32'd500, 32'd3, 32'd166, 1'b1, 1'b0);
    run_check("b2b_second", 2'b11, 32'd500, 32'd3, 32'd2, 1'b0, 1'b0);

    // Reset mid-operation aborts at once and produces no done.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'd999;
    bus.b     = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    run_check("after_abort", 2'b01, 32'd999, 32'd9, 32'd111, 1'b1, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = -32'($urandom_range(1, 15));
        4: ra = 32'($urandom_range(0, 31));
        default: ;
      endcase
      run_check($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb), 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
